// File: rtl/lfsr_generator_pkg.sv
// Shared LFSR definitions for the link self-test generator and checker.
// Polynomial x^8+x^4+x^3+x^2+1 in Galois form; both link ends import this package.
package lfsr_generator_pkg;

    localparam int unsigned LFSR_W    = 8;
    localparam int unsigned PCNT_W    = 8;
    localparam logic [7:0]  LFSR_TAPS = 8'h1C;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of the de Bruijn-extended Galois LFSR.
// Reused by the link checker so both ends step identically.
module lfsr_next
    import lfsr_generator_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next_c
);

    logic fb_c;

    // The all-zero-low-bits term splices 0x00 into the cycle, giving 256 states.
    always_comb begin
        fb_c     = i_state[LFSR_W-1] ^ (i_state[LFSR_W-2:0] == '0);
        o_next_c = {i_state[LFSR_W-2:0], fb_c} ^ (fb_c ? LFSR_TAPS : '0);
    end

endmodule

// File: rtl/lfsr_generator.sv
// Transmit-side PRBS word source for the 8-bit link self-test.
// Optional error injection is compiled in when LFSR_ERR_INJECT_EN is defined.
module lfsr_generator
    import lfsr_generator_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_SEED = 8'h01,
    parameter int unsigned PERIOD       = 256,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_soft_reset,
    input  logic [7:0]       i_seed,
    input  logic             i_enable,
    input  logic             i_periodic,
    input  logic             i_inject_err,
    output logic [7:0]       o_lfsr,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_word_count
);

    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              valid_q, valid_d;
    logic [LFSR_W-1:0] next_c;
    logic [LFSR_W-1:0] mask_c;

    lfsr_next u_lfsr_next (
        .i_state  (state_q),
        .o_next_c (next_c)
    );

`ifdef LFSR_ERR_INJECT_EN
    logic inject_q, inject_d;

    // A pulse in an emission cycle arms the following word; repeated pulses merge.
    always_comb begin
        inject_d = inject_q | i_inject_err;
        if (i_soft_reset) begin
            inject_d = 1'b0;
        end else if (i_enable) begin
            inject_d = i_inject_err;
        end
        mask_c = inject_q ? LFSR_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) inject_q <= 1'b0;
        else          inject_q <= inject_d;
    end
`else
    logic unused_inject;
    assign unused_inject = i_inject_err;
    assign mask_c        = '0;
`endif

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        period_cnt_d = period_cnt_q;
        word_count_d = word_count_q;
        lfsr_d       = lfsr_q;
        valid_d      = 1'b0;
        if (i_soft_reset) begin
            seed_d       = i_seed;
            state_d      = i_seed;
            period_cnt_d = '0;
            word_count_d = '0;
        end else if (i_enable) begin
            lfsr_d       = state_q ^ mask_c;
            valid_d      = 1'b1;
            word_count_d = word_count_q + CNT_W'(1);
            if (i_periodic && (period_cnt_q == PCNT_W'(PERIOD - 1))) begin
                state_d      = seed_q;
                period_cnt_d = '0;
            end else begin
                state_d      = next_c;
                period_cnt_d = period_cnt_q + PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= DEFAULT_SEED;
            seed_q       <= DEFAULT_SEED;
            period_cnt_q <= '0;
            word_count_q <= '0;
            lfsr_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            period_cnt_q <= period_cnt_d;
            word_count_q <= word_count_d;
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
        end
    end

    assign o_lfsr       = lfsr_q;
    assign o_valid      = valid_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_lfsr_generator.sv
// Directed bench for lfsr_generator (instantiated with PERIOD=4 for periodic-mode checks).
module tb_lfsr_generator;

    logic        clk;
    logic        i_rst_n;
    logic        i_soft_reset;
    logic [7:0]  i_seed;
    logic        i_enable;
    logic        i_periodic;
    logic        i_inject_err;
    logic [7:0]  o_lfsr;
    logic        o_valid;
    logic [15:0] o_word_count;

    int tests_run = 0;
    int tests_failed = 0;

    lfsr_generator #(
        .DEFAULT_SEED (8'h01),
        .PERIOD       (4),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_soft_reset (i_soft_reset),
        .i_seed       (i_seed),
        .i_enable     (i_enable),
        .i_periodic   (i_periodic),
        .i_inject_err (i_inject_err),
        .o_lfsr       (o_lfsr),
        .o_valid      (o_valid),
        .o_word_count (o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic soft_load(input logic [7:0] seed);
        i_soft_reset = 1'b1;
        i_seed       = seed;
        step();
        i_soft_reset = 1'b0;
    endtask

    logic [7:0] exp1 [10];
    logic [7:0] exp3 [8];
    logic [7:0] exp5 [5];
    logic [7:0] exp6 [3];
    logic [7:0] exp4 [4];
    bit         seen [256];
    int         distinct;
    logic [7:0] w1;
    logic [7:0] w2;

    initial begin
        exp1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D};
        exp3 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08};
        exp4 = '{8'h01, 8'h02, 8'h04, 8'h08};
`ifdef LFSR_ERR_INJECT_EN
        exp5 = '{8'h01, 8'h02, 8'h05, 8'h08, 8'h10};
`else
        exp5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
`endif
        exp6 = '{8'h10, 8'h20, 8'h40};

        i_rst_n      = 1'b0;
        i_soft_reset = 1'b0;
        i_seed       = 8'h00;
        i_enable     = 1'b0;
        i_periodic   = 1'b0;
        i_inject_err = 1'b0;
        step();
        step();
        check("reset_lfsr",  32'(o_lfsr), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_count", 32'(o_word_count), 32'h0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Default seed after reset is emitted first.
        i_enable = 1'b1;
        step();
        check("defseed_word", 32'(o_lfsr), 32'h01);
        i_enable = 1'b0;

        // Seed 0x01, ten words through the 0x80 -> 0x00 -> 0x1D splice.
        soft_load(8'h01);
        check("t1_load_valid", 32'(o_valid), 32'h0);
        check("t1_load_count", 32'(o_word_count), 32'h0);
        i_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t1_word%0d", i), 32'(o_lfsr), 32'(exp1[i]));
            check($sformatf("t1_valid%0d", i), 32'(o_valid), 32'h1);
        end
        check("t1_count", 32'(o_word_count), 32'd10);
        i_enable = 1'b0;

        // Free-run from 0xA5: every byte once, then the seed recurs.
        soft_load(8'hA5);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        i_enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            if (i == 0) w1 = o_lfsr;
            if (i == 1) w2 = o_lfsr;
            if (!seen[o_lfsr]) distinct++;
            seen[o_lfsr] = 1'b1;
        end
        check("t2_first",    32'(w1), 32'hA5);
        check("t2_second",   32'(w2), 32'h57);
        check("t2_distinct", 32'(distinct), 32'd256);
        check("t2_count256", 32'(o_word_count), 32'd256);
        step();
        check("t2_word257",  32'(o_lfsr), 32'hA5);
        i_enable = 1'b0;

        // Periodic mode with PERIOD=4.
        soft_load(8'h01);
        i_periodic = 1'b1;
        i_enable   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t3_word%0d", i), 32'(o_lfsr), 32'(exp3[i]));
            check($sformatf("t3_valid%0d", i), 32'(o_valid), 32'h1);
        end
        i_enable   = 1'b0;
        i_periodic = 1'b0;

        // Gapped enable: 1 on, 2 off; output holds in the gaps.
        soft_load(8'h01);
        for (int i = 0; i < 4; i++) begin
            i_enable = 1'b1;
            step();
            check($sformatf("t4_word%0d", i), 32'(o_lfsr), 32'(exp4[i]));
            check($sformatf("t4_von%0d", i), 32'(o_valid), 32'h1);
            i_enable = 1'b0;
            for (int g = 0; g < 2; g++) begin
                step();
                check($sformatf("t4_voff%0d_%0d", i, g), 32'(o_valid), 32'h0);
                check($sformatf("t4_hold%0d_%0d", i, g), 32'(o_lfsr), 32'(exp4[i]));
            end
        end
        check("t4_count", 32'(o_word_count), 32'd4);

        // Inject pulse in the emission cycle of word 2 corrupts word 3 only.
        soft_load(8'h01);
        i_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_inject_err = (i == 1);
            step();
            check($sformatf("t5_word%0d", i), 32'(o_lfsr), 32'(exp5[i]));
        end
        i_inject_err = 1'b0;

        // Soft reset wins over enable in the same cycle.
        i_soft_reset = 1'b1;
        i_seed       = 8'h10;
        step();
        i_soft_reset = 1'b0;
        check("t6_valid", 32'(o_valid), 32'h0);
        check("t6_count", 32'(o_word_count), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_word%0d", i), 32'(o_lfsr), 32'(exp6[i]));
        end
        check("t6_count3", 32'(o_word_count), 32'd3);

        // Async reset mid-stream clears outputs immediately, state back to default seed.
        @(negedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'h0);
        check("arst_lfsr",  32'(o_lfsr), 32'h0);
        check("arst_count", 32'(o_word_count), 32'h0);
        @(negedge clk);
        i_rst_n = 1'b1;
        step();
        check("arst_resume", 32'(o_lfsr), 32'h01);
        i_enable = 1'b0;
        step();
        check("final_idle", 32'(o_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
